dither_fs_engine: RTL and testbench

- Parametrised successor to the single-bit-error dithering drawer.
- Accepts a rectangle and a flat input colour from the command registers. Quantises every pixel of the rectangle to OUT_BITS using Floyd-Steinberg error diffusion (or plain rounding when MODE=0).
- Writes one byte per pixel to the framebuffer through the de_* request/acknowledge bus.
- Sits beside the other drawing engines on the same req/ack/busy command port and shares the de_* memory arbiter.

---
 rtl/dither_fs_engine.sv | 210 +++++++++++++++++++++
 tb/tb_dither_fs_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_fs_engine.sv
// dither_fs_engine
//   Rectangle fill engine that quantises a flat input colour to OUT_BITS per
//   pixel with Floyd-Steinberg error diffusion (MODE=1) or plain rounding
//   (MODE=0). It writes one byte per pixel to the framebuffer over the de_*
//   request/acknowledge bus.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req / ack / busy      command handshake: ack pulses once per accepted command
//   r0..r3                x_start, y_start, x_end, y_end (both ends inclusive)
//   r4                    colour, bits [IN_W-1:0] used
//   r5..r7                unused
//   de_req / de_ack       memory write handshake
//   de_addr               word address (pixel byte address >> 2)
//   de_nbyte              active-low byte enables
//   de_rnw                always 0 (write only)
//   de_w_data             quantised pixel replicated into all four byte lanes
//   de_r_data             unused
module dither_fs_engine #(
    parameter int SCREEN_W = 640,
    parameter int IN_W     = 8,
    parameter int OUT_BITS = 3,
    parameter int ADDR_W   = 20,
    parameter int MODE     = 1,
    parameter int ERR_W    = IN_W - OUT_BITS + 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    input  logic [15:0]       r5,
    input  logic [15:0]       r6,
    input  logic [15:0]       r7,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-3:0] de_addr,
    output logic [3:0]        de_nbyte,
    output logic              de_rnw,
    output logic [31:0]       de_w_data,
    input  logic [31:0]       de_r_data
);
    localparam int S  = IN_W - OUT_BITS;
    localparam int XW = $clog2(SCREEN_W);
    localparam int VW = IN_W + ERR_W;
    localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);
    localparam logic [IN_W:0] HALF = (IN_W + 1)'(1 << (S - 1));

    typedef enum logic [2:0] {IDLE, CLEAR, CALC, WRITE, DONE} state_t;
    state_t state;

    logic [15:0]             x_start, x_end, y_end, x, y;
    logic [IN_W-1:0]         colour;
    logic [XW-1:0]           clr_cnt;
    logic signed [ERR_W-1:0] linebuf [SCREEN_W];
    // carry: 7e headed right; below: 1e headed down-right;
    // prev_val: next-row value for x-1, still waiting for its 3e share.
    logic signed [ERR_W-1:0] carry, below, prev_val;

    logic unused_bits;
    assign unused_bits = ^{r4[15:IN_W], r5, r6, r7, de_r_data};
    assign de_rnw = 1'b0;

    // Clamp v to the legal pixel range [0, 2^IN_W-1].
    function automatic logic [IN_W-1:0] clamp_pix(input logic signed [VW-1:0] v);
        if (v[VW-1])              return '0;
        else if (|v[VW-2:IN_W])   return '1;
        else                      return v[IN_W-1:0];
    endfunction

    // Round-to-nearest down to OUT_BITS, saturating at the top code.
    function automatic logic [OUT_BITS-1:0] quantise(input logic [IN_W-1:0] p);
        logic [IN_W:0] r;
        r = {1'b0, p} + HALF;
        if (r[IN_W]) return '1;
        return r[IN_W-1:S];
    endfunction

    function automatic logic signed [ERR_W-1:0] quant_err(input logic [IN_W-1:0] p,
                                                          input logic [OUT_BITS-1:0] q);
        logic signed [IN_W+1:0] d;
        d = $signed({2'b00, p}) - $signed({2'b00, q, {S{1'b0}}});
        return ERR_W'(d);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lo);
        return ~(4'b0001 << lo);
    endfunction

    logic [15:0] xe_clamp;
    logic        rect_ok;
    assign xe_clamp = (r2 > X_MAX) ? X_MAX : r2;
    assign rect_ok  = (xe_clamp >= r0) && (r3 >= r1);

    // ---- stage p0: combinational pixel evaluation during CALC ----
    logic [XW-1:0]           xi;
    logic signed [ERR_W-1:0] acc_p0, acc_sh_p0, e_p0, e3_p0, e5_p0, e7_p0;
    logic signed [VW-1:0]    v_p0;
    logic [IN_W-1:0]         pix_p0;
    logic [OUT_BITS-1:0]     q_p0;
    logic [ADDR_W-1:0]       addr_p0;

    assign xi      = x[XW-1:0];
    assign addr_p0 = ADDR_W'(32'(x) + 32'(y) * 32'(SCREEN_W));

    always_comb begin
        acc_p0 = '0;
        if (MODE != 0) acc_p0 = linebuf[xi] + carry;
        acc_sh_p0 = acc_p0 >>> 4;
        v_p0   = $signed({{ERR_W{1'b0}}, colour})
               + $signed({{IN_W{acc_sh_p0[ERR_W-1]}}, acc_sh_p0});
        pix_p0 = clamp_pix(v_p0);
        q_p0   = quantise(pix_p0);
        e_p0   = quant_err(pix_p0, q_p0);
        e3_p0  = (e_p0 <<< 1) + e_p0;
        e5_p0  = (e_p0 <<< 2) + e_p0;
        e7_p0  = (e_p0 <<< 3) - e_p0;
    end

    // ---- stage p1: control FSM and registered bus outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= 1'b0;
            busy      <= 1'b0;
            de_req    <= 1'b0;
            de_nbyte  <= 4'b1111;
            de_addr   <= '0;
            de_w_data <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    ack   <= 1'b1;
                    busy  <= 1'b1;
                    state <= rect_ok ? CLEAR : DONE;
                end
                CLEAR: if (clr_cnt == XW'(SCREEN_W - 1)) state <= CALC;
                CALC: begin
                    de_req    <= 1'b1;
                    de_addr   <= addr_p0[ADDR_W-1:2];
                    de_nbyte  <= lane_mask(addr_p0[1:0]);
                    de_w_data <= {4{{(8 - OUT_BITS){1'b0}}, q_p0}};
                    state     <= WRITE;
                end
                WRITE: if (de_ack) begin
                    de_req   <= 1'b0;
                    de_nbyte <= 4'b1111;
                    if (x == x_end && y == y_end) state <= DONE;
                    else                          state <= CALC;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: datapath state (command latch, counters, error buffers) ----
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (req) begin
                x_start <= r0;
                x_end   <= xe_clamp;
                y_end   <= r3;
                colour  <= r4[IN_W-1:0];
                x       <= r0;
                y       <= r1;
                clr_cnt <= '0;
            end
            CLEAR: begin
                linebuf[clr_cnt] <= '0;
                clr_cnt          <= clr_cnt + 1'b1;
                carry            <= '0;
                below            <= '0;
            end
            CALC: if (MODE != 0) begin
                // x-1 is finished once it receives 3e from this pixel; the
                // value for x itself stays in prev_val so linebuf[x+1] keeps
                // the previous row's error until it is read.
                if (x != x_start) linebuf[xi - 1'b1] <= prev_val + e3_p0;
                prev_val <= e5_p0 + below;
                below    <= (x != x_end) ? e_p0 : '0;
                carry    <= e7_p0;
            end
            WRITE: begin
                // Last column of a row has no right neighbour to complete it.
                if (MODE != 0 && x == x_end) linebuf[xi] <= prev_val;
                if (de_ack) begin
                    if (x == x_end) begin
                        x     <= x_start;
                        y     <= y + 16'd1;
                        carry <= '0;
                        below <= '0;
                    end else begin
                        x <= x + 16'd1;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dither_fs_engine.sv
module tb_dither_fs_engine;
    localparam int SW = 640;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req0, req1, de_ack0, de_ack1;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [31:0] de_r_data;
    logic        ack0, busy0, de_req0, de_rnw0;
    logic        ack1, busy1, de_req1, de_rnw1;
    logic [17:0] de_addr0, de_addr1;
    logic [3:0]  de_nbyte0, de_nbyte1;
    logic [31:0] de_w_data0, de_w_data1;

    dither_fs_engine #(.SCREEN_W(SW), .IN_W(8), .OUT_BITS(3), .ADDR_W(20), .MODE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .ack(ack0), .busy(busy0),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .de_req(de_req0), .de_ack(de_ack0), .de_addr(de_addr0), .de_nbyte(de_nbyte0),
        .de_rnw(de_rnw0), .de_w_data(de_w_data0), .de_r_data(de_r_data));

    dither_fs_engine #(.SCREEN_W(SW), .IN_W(8), .OUT_BITS(3), .ADDR_W(20), .MODE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .ack(ack1), .busy(busy1),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .de_req(de_req1), .de_ack(de_ack1), .de_addr(de_addr1), .de_nbyte(de_nbyte1),
        .de_rnw(de_rnw1), .de_w_data(de_w_data1), .de_r_data(de_r_data));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void sample(input int which, output logic rq, output logic [17:0] a,
                                   output logic [3:0] nb, output logic [31:0] d,
                                   output logic ak, output logic bz);
        if (which == 0) begin
            rq = de_req0; a = de_addr0; nb = de_nbyte0; d = de_w_data0; ak = ack0; bz = busy0;
        end else begin
            rq = de_req1; a = de_addr1; nb = de_nbyte1; d = de_w_data1; ak = ack1; bz = busy1;
        end
    endfunction

    function automatic logic [3:0] exp_nb(input int a);
        case (a % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic set_req(input int which, input logic v);
        if (which == 0) req0 = v; else req1 = v;
    endtask

    task automatic set_ack(input int which, input logic v);
        if (which == 0) de_ack0 = v; else de_ack1 = v;
    endtask

    // Issue a command and confirm the one-cycle ack pulse.
    task automatic cmd(input int which, input logic [15:0] xs, input logic [15:0] ys,
                       input logic [15:0] xe, input logic [15:0] ye, input logic [15:0] col,
                       input string tag);
        logic rq, ak, bz; logic [17:0] a; logic [3:0] nb; logic [31:0] d;
        r0 = xs; r1 = ys; r2 = xe; r3 = ye; r4 = col;
        set_req(which, 1'b1);
        @(negedge clk);
        sample(which, rq, a, nb, d, ak, bz);
        check({tag, " ack_pulse"}, 32'(ak), 32'd1);
        check({tag, " busy_set"}, 32'(bz), 32'd1);
        set_req(which, 1'b0);
        @(negedge clk);
        sample(which, rq, a, nb, d, ak, bz);
        check({tag, " ack_one_cycle"}, 32'(ak), 32'd0);
    endtask

    task automatic wait_req(input int which, output int waited, output logic seen);
        logic ak, bz; logic [17:0] a; logic [3:0] nb; logic [31:0] d;
        waited = 0;
        sample(which, seen, a, nb, d, ak, bz);
        while (!seen && waited < 2000) begin
            @(negedge clk);
            waited++;
            sample(which, seen, a, nb, d, ak, bz);
        end
    endtask

    // Wait for one write, check it against byte address pa and code q, ack at once.
    task automatic expect_write(input int which, input string tag, input int pa, input int q,
                                output int waited);
        logic rq, ak, bz; logic [17:0] a; logic [3:0] nb; logic [31:0] d;
        wait_req(which, waited, rq);
        check({tag, " de_req"}, 32'(rq), 32'd1);
        if (rq) begin
            sample(which, rq, a, nb, d, ak, bz);
            check({tag, " addr"}, 32'(a), 32'(pa / 4));
            check({tag, " nbyte"}, 32'(nb), 32'(exp_nb(pa)));
            check({tag, " data"}, d, 32'(q * 32'h01010101));
            set_ack(which, 1'b1);
            @(negedge clk);
            set_ack(which, 1'b0);
            sample(which, rq, a, nb, d, ak, bz);
            check({tag, " req_drop"}, 32'(rq), 32'd0);
        end
    endtask

    task automatic wait_idle(input int which, input string tag);
        logic rq, ak, bz; logic [17:0] a; logic [3:0] nb; logic [31:0] d;
        int n;
        n = 0;
        sample(which, rq, a, nb, d, ak, bz);
        while (bz && n < 20) begin
            @(negedge clk);
            n++;
            sample(which, rq, a, nb, d, ak, bz);
        end
        check({tag, " busy_clear"}, 32'(bz), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int high;
        logic rq, ak, bz, seen; logic [17:0] a; logic [3:0] nb; logic [31:0] d;
        int t2_q[4]   = '{5, 4, 5, 4};
        int fs_q[4]   = '{5, 4, 4, 5};
        int fs_pa[4]  = '{0, 1, 640, 641};

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; de_ack0 = 1'b0; de_ack1 = 1'b0;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0; r6 = '0; r7 = '0;
        de_r_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst ack", 32'(ack0), 32'd0);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst de_req", 32'(de_req0), 32'd0);
        check("rst nbyte", 32'(de_nbyte0), 32'hF);
        check("rst addr", 32'(de_addr0), 32'd0);
        check("rst wdata", de_w_data0, 32'd0);
        check("rst rnw", 32'(de_rnw0), 32'd0);
        check("rst busy m0", 32'(busy1), 32'd0);
        check("rst de_req m0", 32'(de_req1), 32'd0);
        check("rst rnw m0", 32'(de_rnw1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mid-grey: zero error, all pixels code 4
        cmd(0, 16'd0, 16'd0, 16'd3, 16'd0, 16'h0080, "t1");
        for (int i = 0; i < 4; i++) expect_write(0, $sformatf("t1 px%0d", i), i, 4, w);
        wait_idle(0, "t1");

        // 0x90: error carried rightwards alternates 5/4
        cmd(0, 16'd0, 16'd0, 16'd3, 16'd0, 16'h0090, "t2");
        for (int i = 0; i < 4; i++) expect_write(0, $sformatf("t2 px%0d", i), i, t2_q[i], w);
        wait_idle(0, "t2");

        // 2x2 at 0x90: second row consumes the next-row buffer
        cmd(0, 16'd0, 16'd0, 16'd1, 16'd1, 16'h0090, "fs");
        for (int i = 0; i < 4; i++) expect_write(0, $sformatf("fs px%0d", i), fs_pa[i], fs_q[i], w);
        wait_idle(0, "fs");

        // White 8x2: saturation everywhere
        cmd(0, 16'd0, 16'd0, 16'd7, 16'd1, 16'h00FF, "t3");
        for (int yy = 0; yy < 2; yy++)
            for (int xx = 0; xx < 8; xx++)
                expect_write(0, $sformatf("t3 x%0d y%0d", xx, yy), xx + yy * SW, 7, w);
        wait_idle(0, "t3");

        // Rounding-only instance, 4x4 at 0x90
        cmd(1, 16'd0, 16'd0, 16'd3, 16'd3, 16'h0090, "t4");
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 4; xx++)
                expect_write(1, $sformatf("t4 x%0d y%0d", xx, yy), xx + yy * SW, 5, w);
        wait_idle(1, "t4");

        // Single pixel at (3,2) with a slow ack; req while busy is ignored
        cmd(0, 16'd3, 16'd2, 16'd3, 16'd2, 16'h0080, "t5");
        wait_req(0, w, seen);
        check("t5 de_req", 32'(seen), 32'd1);
        sample(0, rq, a, nb, d, ak, bz);
        check("t5 addr", 32'(a), 32'd320);
        check("t5 nbyte", 32'(nb), 32'b0111);
        check("t5 data", d, 32'h04040404);
        req0 = 1'b1;
        high = 1;
        repeat (5) begin
            @(negedge clk);
            sample(0, rq, a, nb, d, ak, bz);
            if (rq) high++;
            check("t5 no_ack_while_busy", 32'(ak), 32'd0);
            check("t5 addr_stable", 32'(a), 32'd320);
            check("t5 nbyte_stable", 32'(nb), 32'b0111);
            check("t5 data_stable", d, 32'h04040404);
        end
        req0 = 1'b0;
        check("t5 req_high_cycles", 32'(high), 32'd6);
        de_ack0 = 1'b1;
        @(negedge clk);
        de_ack0 = 1'b0;
        sample(0, rq, a, nb, d, ak, bz);
        check("t5 req_drop", 32'(rq), 32'd0);
        check("t5 busy_after_1", 32'(bz), 32'd1);
        @(negedge clk);
        sample(0, rq, a, nb, d, ak, bz);
        check("t5 busy_after_2", 32'(bz), 32'd0);
        check("t5 ack_quiet", 32'(ak), 32'd0);

        // x_end beyond the screen is clamped to SW-1
        cmd(0, 16'd638, 16'd0, 16'hFFFF, 16'd0, 16'h0080, "clamp");
        expect_write(0, "clamp x638", 638, 4, w);
        expect_write(0, "clamp x639", 639, 4, w);
        sample(0, rq, a, nb, d, ak, bz);
        check("clamp busy_1", 32'(bz), 32'd1);
        @(negedge clk);
        sample(0, rq, a, nb, d, ak, bz);
        check("clamp busy_2", 32'(bz), 32'd0);

        // Empty rectangles: ack, no writes, busy clears
        cmd(0, 16'd5, 16'd0, 16'd2, 16'd0, 16'h0080, "badx");
        check("badx busy", 32'(busy0), 32'd0);
        high = 0;
        repeat (4) begin @(negedge clk); if (de_req0) high++; end
        check("badx no_de_req", 32'(high), 32'd0);
        cmd(0, 16'd0, 16'd3, 16'd0, 16'd1, 16'h0080, "bady");
        check("bady busy", 32'(busy0), 32'd0);
        high = 0;
        repeat (4) begin @(negedge clk); if (de_req0) high++; end
        check("bady no_de_req", 32'(high), 32'd0);

        // Reset while a write is waiting
        cmd(0, 16'd5, 16'd0, 16'd5, 16'd0, 16'h0090, "rst");
        wait_req(0, w, seen);
        check("rst de_req_up", 32'(seen), 32'd1);
        check("rst pre_addr", 32'(de_addr0), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid de_req", 32'(de_req0), 32'd0);
        check("rstmid busy", 32'(busy0), 32'd0);
        check("rstmid nbyte", 32'(de_nbyte0), 32'hF);
        check("rstmid addr", 32'(de_addr0), 32'd0);
        check("rstmid wdata", de_w_data0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Restart: full CLEAR before the first write
        cmd(0, 16'd0, 16'd0, 16'd1, 16'd0, 16'h0090, "re");
        expect_write(0, "re px0", 0, 5, w);
        check("re clear_cycles", 32'(w), 32'(SW));
        expect_write(0, "re px1", 1, 4, w);
        wait_idle(0, "re");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
